// File: rtl/fp16_pkg.sv
// Shared fp16 constants and packed record types for the sqrt output path.
package fp16_pkg;

   localparam logic [4:0]  FP16_EXP_MAX = 5'h1F;
   localparam logic [15:0] FP16_QNAN    = 16'h7E00;
   localparam logic [15:0] FP16_PINF    = 16'h7C00;

   typedef struct packed {
      logic nan;
      logic pinf;
      logic ninf;
      logic zero;
      logic sign;
   } fp16_class_t;

   typedef struct packed {
      logic       sign;
      logic [4:0] exp;
      logic [9:0] mant;
      logic       invalid;
   } fp16_result_t;

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO; push and pop may coincide even when full or empty.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             do_push;
   logic             do_pop;

   assign full     = (count == (AW+1)'(DEPTH));
   assign empty    = (count == '0);
   assign pop_data = mem[rd_ptr];

   // A push into a full FIFO is legal only when the head leaves in the same cycle.
   assign do_pop  = pop & !empty;
   assign do_push = push & (!full | do_pop);

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (do_pop)
            rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/fp16_sqrt_pack.sv
// Pairs queued operand classes with raw sqrt core results, rounds, substitutes
// IEEE specials and delivers fp16 words under credit-based flow control.
module fp16_sqrt_pack
   import fp16_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        c_valid,
   output logic        c_ready,
   input  logic        c_is_nan,
   input  logic        c_is_pinf,
   input  logic        c_is_ninf,
   input  logic        c_is_normal,
   input  logic        c_is_subnormal,
   input  logic        c_sign,
   input  logic        r_valid,
   input  logic [4:0]  r_exp,
   input  logic [10:0] r_mant,
   input  logic        r_round,
   input  logic        r_sticky,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        out_sign,
   output logic [4:0]  out_exp,
   output logic [9:0]  out_mant,
   output logic        out_invalid,
   output logic        err_orphan
);

   localparam int CW = $clog2(DEPTH) + 1;

   // Handshakes: c beat moves on c_valid & c_ready; result moves on
   // out_valid & out_ready; r_valid is a strobe with no back-pressure.

   logic [CW-1:0] inflight;
   logic          c_accept;
   logic          out_accept;
   logic          r_take;
   logic          cls_empty;
   logic          cls_full;
   logic          out_empty;
   logic          out_full;
   fp16_class_t   cls_in;
   fp16_class_t   cls_head;
   fp16_result_t  res;
   fp16_result_t  out_head;
   logic          inc;
   logic [10:0]   m_sum;
   logic          unused_bits;

   assign c_ready    = (inflight < CW'(DEPTH));
   assign c_accept   = c_valid & c_ready;
   assign out_valid  = !out_empty;
   assign out_accept = out_valid & out_ready;
   assign r_take     = r_valid & !cls_empty;

   // The hidden bit never reaches the packed word; full flags are implied by the credit bound.
   assign unused_bits = &{1'b0, r_mant[10], cls_full, out_full};

   always_comb begin
      cls_in      = '0;
      cls_in.nan  = c_is_nan;
      cls_in.pinf = c_is_pinf;
      cls_in.ninf = c_is_ninf;
      cls_in.zero = !(c_is_nan | c_is_pinf | c_is_ninf | c_is_normal | c_is_subnormal);
      cls_in.sign = c_sign;
   end

   sync_fifo #(.WIDTH(5), .DEPTH(DEPTH)) u_cls_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (c_accept),
      .push_data (cls_in),
      .pop       (r_take),
      .pop_data  (cls_head),
      .full      (cls_full),
      .empty     (cls_empty)
   );

   always_comb begin
      res   = '0;
      inc   = r_round & (r_sticky | r_mant[0]);
      m_sum = {1'b0, r_mant[9:0]} + {10'd0, inc};
      if (cls_head.nan)
         res = fp16_result_t'({FP16_QNAN, 1'b0});
      else if (cls_head.ninf)
         res = fp16_result_t'({FP16_QNAN, 1'b1});
      else if (cls_head.pinf)
         res = fp16_result_t'({FP16_PINF, 1'b0});
      else if (cls_head.zero)
         res = fp16_result_t'({cls_head.sign, 16'h0000});
      else if (cls_head.sign)
         res = fp16_result_t'({FP16_QNAN, 1'b1});
      else if (m_sum[10]) begin
         // Mantissa overflow bumps the exponent; anything reaching 31 becomes +inf.
         if (r_exp >= FP16_EXP_MAX - 5'd1)
            res = fp16_result_t'({FP16_PINF, 1'b0});
         else
            res = fp16_result_t'({1'b0, r_exp + 5'd1, 10'd0, 1'b0});
      end else
         res = fp16_result_t'({1'b0, r_exp, m_sum[9:0], 1'b0});
   end

   sync_fifo #(.WIDTH(17), .DEPTH(DEPTH)) u_out_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (r_take),
      .push_data (res),
      .pop       (out_accept),
      .pop_data  (out_head),
      .full      (out_full),
      .empty     (out_empty)
   );

   // Storage is not reset, so present zeros whenever nothing is buffered.
   assign out_sign    = out_valid ? out_head.sign    : 1'b0;
   assign out_exp     = out_valid ? out_head.exp     : 5'd0;
   assign out_mant    = out_valid ? out_head.mant    : 10'd0;
   assign out_invalid = out_valid ? out_head.invalid : 1'b0;

   always_ff @(posedge clk) begin
      if (rst) begin
         inflight   <= '0;
         err_orphan <= 1'b0;
      end else begin
         err_orphan <= r_valid & cls_empty;
         case ({c_accept, out_accept})
            2'b10:   inflight <= inflight + CW'(1);
            2'b01:   inflight <= inflight - CW'(1);
            default: inflight <= inflight;
         endcase
      end
   end

endmodule

// File: tb/tb_fp16_sqrt_pack.sv
// Directed bench for fp16_sqrt_pack with an in-order expected-result queue.
module tb_fp16_sqrt_pack;

   logic        clk = 1'b0;
   logic        rst;
   logic        c_valid;
   logic        c_ready;
   logic        c_is_nan, c_is_pinf, c_is_ninf, c_is_normal, c_is_subnormal, c_sign;
   logic        r_valid;
   logic [4:0]  r_exp;
   logic [10:0] r_mant;
   logic        r_round, r_sticky;
   logic        out_valid;
   logic        out_ready;
   logic        out_sign;
   logic [4:0]  out_exp;
   logic [9:0]  out_mant;
   logic        out_invalid;
   logic        err_orphan;

   logic [16:0] exp_q[$];
   int          n_assert = 0;
   int          n_fail   = 0;

   fp16_sqrt_pack #(.DEPTH(4)) dut (
      .clk            (clk),
      .rst            (rst),
      .c_valid        (c_valid),
      .c_ready        (c_ready),
      .c_is_nan       (c_is_nan),
      .c_is_pinf      (c_is_pinf),
      .c_is_ninf      (c_is_ninf),
      .c_is_normal    (c_is_normal),
      .c_is_subnormal (c_is_subnormal),
      .c_sign         (c_sign),
      .r_valid        (r_valid),
      .r_exp          (r_exp),
      .r_mant         (r_mant),
      .r_round        (r_round),
      .r_sticky       (r_sticky),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_sign       (out_sign),
      .out_exp        (out_exp),
      .out_mant       (out_mant),
      .out_invalid    (out_invalid),
      .err_orphan     (err_orphan)
   );

   // clock / reset
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_assert++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   // driver tasks
   task automatic set_class(input logic nan, input logic pinf, input logic ninf,
                            input logic normal, input logic sub, input logic sign);
      c_is_nan = nan; c_is_pinf = pinf; c_is_ninf = ninf;
      c_is_normal = normal; c_is_subnormal = sub; c_sign = sign;
   endtask

   task automatic send_class(input logic nan, input logic pinf, input logic ninf,
                             input logic normal, input logic sub, input logic sign);
      check("c_ready_before_beat", {31'd0, c_ready}, 32'd1);
      set_class(nan, pinf, ninf, normal, sub, sign);
      c_valid = 1'b1;
      cycle();
      c_valid = 1'b0;
   endtask

   task automatic drive_result(input logic [4:0] e, input logic [10:0] m,
                               input logic rnd, input logic stk);
      r_exp = e; r_mant = m; r_round = rnd; r_sticky = stk;
      r_valid = 1'b1;
   endtask

   task automatic send_result(input logic [4:0] e, input logic [10:0] m, input logic rnd,
                              input logic stk, input logic [15:0] word, input logic inv);
      drive_result(e, m, rnd, stk);
      exp_q.push_back({word, inv});
      cycle();
      r_valid = 1'b0;
   endtask

   task automatic wait_drain(input string tag);
      int n = 0;
      while (exp_q.size() != 0 && n < 50) begin
         cycle();
         n++;
      end
      check(tag, exp_q.size(), 32'd0);
   endtask

   // scoreboard: compare each accepted output against the queue head
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         if (exp_q.size() == 0)
            check("unexpected_output", {15'd0, out_sign, out_exp, out_mant, out_invalid}, 32'h1FFFF);
         else
            check("out_word", {15'd0, out_sign, out_exp, out_mant, out_invalid},
                  {15'd0, exp_q.pop_front()});
      end
   end

   initial begin
      rst = 1'b1; c_valid = 1'b0; r_valid = 1'b0; out_ready = 1'b0;
      set_class(0, 0, 0, 0, 0, 0);
      r_exp = '0; r_mant = '0; r_round = 1'b0; r_sticky = 1'b0;
      cycle(); cycle();
      rst = 1'b0;
      cycle();

      // reset state
      check("rst_c_ready",     {31'd0, c_ready}, 32'd1);
      check("rst_out_valid",   {31'd0, out_valid}, 32'd0);
      check("rst_out_fields",  {15'd0, out_sign, out_exp, out_mant, out_invalid}, 32'd0);
      check("rst_err_orphan",  {31'd0, err_orphan}, 32'd0);

      // sqrt(4.0) with one-cycle latency
      out_ready = 1'b1;
      send_class(0, 0, 0, 1, 0, 0);
      send_result(5'd16, 11'h400, 0, 0, 16'h4000, 1'b0);
      check("latency_out_valid", {31'd0, out_valid}, 32'd1);
      wait_drain("drain_sqrt4");

      // rounding: tie with odd lsb carries into exponent; even lsb stays
      send_class(0, 0, 0, 1, 0, 0);
      send_result(5'd15, 11'h7FF, 1, 0, 16'h4000, 1'b0);
      send_class(0, 0, 0, 1, 0, 0);
      send_result(5'd15, 11'h7FE, 1, 0, 16'h3FFE, 1'b0);
      send_class(0, 0, 0, 0, 1, 0);
      send_result(5'd14, 11'h5A5, 1, 1, 16'h39A6, 1'b0);
      wait_drain("drain_round");

      // specials in sequence
      send_class(1, 0, 0, 0, 0, 0); send_result(5'd10, 11'h500, 1, 1, 16'h7E00, 1'b0);
      send_class(0, 0, 1, 0, 0, 1); send_result(5'd10, 11'h500, 1, 1, 16'h7E00, 1'b1);
      send_class(0, 1, 0, 0, 0, 0); send_result(5'd10, 11'h500, 1, 1, 16'h7C00, 1'b0);
      send_class(0, 0, 0, 0, 0, 0); send_result(5'd10, 11'h500, 1, 1, 16'h0000, 1'b0);
      send_class(0, 0, 0, 0, 0, 1); send_result(5'd10, 11'h500, 1, 1, 16'h8000, 1'b0);
      send_class(0, 0, 0, 1, 0, 1); send_result(5'd10, 11'h500, 1, 1, 16'h7E00, 1'b1);
      wait_drain("drain_specials");

      // back-pressure: four credits, fifth beat held off
      out_ready = 1'b0;
      set_class(0, 0, 0, 1, 0, 0);
      for (int i = 0; i < 4; i++) begin
         check("bp_c_ready_open", {31'd0, c_ready}, 32'd1);
         c_valid = 1'b1;
         cycle();
      end
      check("bp_c_ready_closed", {31'd0, c_ready}, 32'd0);
      cycle();
      check("bp_fifth_held", {31'd0, c_ready}, 32'd0);
      send_result(5'd15, 11'h400, 0, 0, 16'h3C00, 1'b0);
      send_result(5'd15, 11'h600, 0, 0, 16'h3E00, 1'b0);
      send_result(5'd17, 11'h7FF, 1, 1, 16'h4800, 1'b0);
      send_result(5'd15, 11'h402, 1, 0, 16'h3C02, 1'b0);
      check("bp_out_valid", {31'd0, out_valid}, 32'd1);
      check("bp_head_stable", {15'd0, out_sign, out_exp, out_mant, out_invalid}, {15'd0, 16'h3C00, 1'b0});
      out_ready = 1'b1;
      cycle();
      out_ready = 1'b0;
      check("bp_credit_return", {31'd0, c_ready}, 32'd1);
      cycle();
      c_valid = 1'b0;
      check("bp_fifth_taken", {31'd0, c_ready}, 32'd0);
      send_result(5'd30, 11'h7FF, 1, 0, 16'h7C00, 1'b0);
      out_ready = 1'b1;
      wait_drain("drain_bp");
      cycle();
      check("bp_c_ready_final", {31'd0, c_ready}, 32'd1);

      // orphan result
      drive_result(5'd16, 11'h400, 0, 0);
      cycle();
      r_valid = 1'b0;
      check("orphan_pulse", {31'd0, err_orphan}, 32'd1);
      check("orphan_no_out", {31'd0, out_valid}, 32'd0);
      check("orphan_c_ready", {31'd0, c_ready}, 32'd1);
      cycle();
      check("orphan_pulse_end", {31'd0, err_orphan}, 32'd0);

      // class and result in the same cycle on an empty FIFO
      set_class(1, 0, 0, 0, 0, 0);
      c_valid = 1'b1;
      drive_result(5'd16, 11'h400, 0, 0);
      cycle();
      c_valid = 1'b0; r_valid = 1'b0;
      check("same_cycle_orphan", {31'd0, err_orphan}, 32'd1);
      check("same_cycle_no_out", {31'd0, out_valid}, 32'd0);
      send_result(5'd16, 11'h400, 0, 0, 16'h7E00, 1'b0);
      wait_drain("drain_same_cycle");

      // reset mid-flight
      out_ready = 1'b0;
      send_class(0, 0, 0, 1, 0, 0);
      send_class(0, 0, 0, 1, 0, 0);
      send_class(0, 0, 0, 1, 0, 0);
      drive_result(5'd16, 11'h400, 0, 0);
      cycle();
      check("pre_rst_out_valid", {31'd0, out_valid}, 32'd1);
      rst = 1'b1;
      cycle();
      rst = 1'b0; r_valid = 1'b0;
      exp_q.delete();
      check("mid_rst_c_ready", {31'd0, c_ready}, 32'd1);
      check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("mid_rst_no_orphan", {31'd0, err_orphan}, 32'd0);
      drive_result(5'd16, 11'h400, 0, 0);
      cycle();
      r_valid = 1'b0;
      check("post_rst_orphan", {31'd0, err_orphan}, 32'd1);
      check("post_rst_no_out", {31'd0, out_valid}, 32'd0);
      cycle();

      // final report
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
